mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//  Memory-side responder for the core's memory bus (memread/memwrite/adr/writedata -> memdata).
//  Services one word read or write at a time from an internal word array.
//  Inserts LATENCY wait cycles, signals completion with memready, flags bad accesses.
//  Sits between the mips32 core and backing storage; also serves as the bench memory model.
// PARAMETERS
//  WIDTH     32  data/address width in bits
//  ADDRBITS  8   log2(word count); array holds 2**ADDRBITS words
//  LATENCY   2   cycles from request acceptance to memready; legal range 1..15
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         asynchronous, active-high reset
//  memread    in   1         read request
//  memwrite   in   1         write request
//  adr        in   WIDTH     byte address; word aligned
//  writedata  in   WIDTH     write data
//  memdata    out  WIDTH     registered read data, valid while memready=1
//  memready   out  1         one-cycle completion pulse
//  busy       out  1         request in flight; new requests ignored
//  err        out  1         sticky error flag
//  err_clr    in   1         clears err
// BEHAVIOUR
//  Reset values: memdata=0, memready=0, busy=0, err=0, state IDLE. The array is not cleared.
//  Reset mid-operation aborts the request. A pending write is never committed.
//  States: IDLE, WAIT, RESP.
//  IDLE: on memread|memwrite, capture op/adr/writedata at the edge.
//    Go to WAIT with cnt=LATENCY-1, or to RESP directly if LATENCY=1.
//  WAIT: decrement cnt each cycle; at cnt==1 go to RESP.
//  RESP: memready=1 for exactly one cycle, then IDLE.
//    Write commits to the array on the edge that leaves RESP.
//    Read: memdata loaded on the edge entering RESP.
//  memready rises exactly LATENCY cycles after the accepting edge.
//  busy=1 in WAIT and RESP. Inputs are ignored while busy.
//  A request held high is re-accepted in the IDLE cycle after RESP.
//    Throughput: one request per LATENCY+1 cycles.
//  memdata holds its last read value until the next read response. Writes do not change it.
//  Word index = adr[ADDRBITS+1:2].
//  Misaligned (adr[1:0]!=0) or out-of-range (adr[WIDTH-1:ADDRBITS+2]!=0) request:
//    handshake completes normally; write suppressed; read returns 0; err set.
//  memread & memwrite together: the write is performed, the read is dropped, err set.
//  err_clr and a new error in the same cycle: err stays 1 (set wins).
//  Unchanged state (LATENCY outside 1..15): elaboration error.
// STRUCTURE
//  Shared include mips_mem_defs.vh holds:
//    state encodings ST_IDLE/ST_WAIT/ST_RESP (2-bit);
//    LATENCY_MIN/LATENCY_MAX; counter width 4.
//  Sub-module mips_mem_array #(WIDTH,ADDRBITS):
//    synchronous write (we, wa, wd); combinational read (ra -> rd).
//  Top-level holds the FSM, wait counter, capture registers, error logic and the memdata register.
// TESTING
//  1. LATENCY=2, write 0xDEADBEEF @0x10 -> busy=1 two cycles, memready at +2.
//     Then read @0x10 -> memdata=0xDEADBEEF with memready.
//  2. Read @0x13 -> memready pulses, memdata=0, err=1; pulse err_clr -> err=0 next cycle.
//  3. memread=memwrite=1 @0x20, writedata=0x5 -> err=1; later read @0x20 returns 0x5.
//  4. Write 0x1234 @0x8 (prior value 0x0), assert reset during WAIT ->
//     memready never pulses, outputs zero; read @0x8 after reset returns 0x0.
//  5. LATENCY=1, memread held high, adr 0,4,8 stepped on each memready ->
//     memready every 2nd cycle, data in order.
//  6. ADDRBITS=8, write 0xFFFF @0x400 -> err=1; read @0x0 unchanged (no aliasing).

Source files
------------

// File: rtl/mips_mem_responder_pkg.sv
// Shared definitions for the mips memory responder: FSM encodings,
// latency limits and the wait-counter width.
package mips_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;
   localparam int CNT_W       = 4;

endpackage

// File: rtl/mips_mem_responder_array.sv
// Backing word store for the memory responder: synchronous write port,
// combinational read port. Contents are deliberately not reset.
module mips_mem_array
   import mips_mem_responder_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int ADDRBITS = 8
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ADDRBITS-1:0] wa,
   input  logic [WIDTH-1:0]    wd,
   input  logic [ADDRBITS-1:0] ra,
   output logic [WIDTH-1:0]    rd
);

   logic [WIDTH-1:0] r_mem [2**ADDRBITS];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[wa] <= wd;
      end
   end

   assign rd = r_mem[ra];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the mips32 core bus: one word access at a time,
// LATENCY cycles to memready, bad accesses complete normally but raise err.
module mips_mem_responder
   import mips_mem_responder_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int ADDRBITS = 8,
   parameter int LATENCY  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memread,
   input  logic             memwrite,
   input  logic [WIDTH-1:0] adr,
   input  logic [WIDTH-1:0] writedata,
   output logic [WIDTH-1:0] memdata,
   output logic             memready,
   output logic             busy,
   output logic             err,
   input  logic             err_clr,
   output logic [1:0]       dbg_state
);

   if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("mips_mem_responder: LATENCY must lie in 1..15");
   end

   state_t               r_state;
   state_t               w_next_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_next_cnt;
   logic                 r_is_wr;
   logic                 r_is_rd;
   logic                 r_bad;
   logic                 r_err_req;
   logic [ADDRBITS-1:0]  r_idx;
   logic [WIDTH-1:0]     r_wd;
   logic [WIDTH-1:0]     r_memdata;
   logic                 r_err;
   logic                 w_idle;
   logic                 w_accept;
   logic                 w_adr_bad;
   logic                 w_cur_rd;
   logic                 w_cur_bad;
   logic                 w_cur_err;
   logic                 w_enter_resp;
   logic                 w_we;
   logic [ADDRBITS-1:0]  w_ra;
   logic [WIDTH-1:0]     w_rd_data;

   // Handshake: a request (memread|memwrite) is taken on any edge seen in
   // IDLE; busy covers WAIT and RESP, during which all inputs are ignored, and
   // memready is high for the single RESP cycle that closes the transaction.
   assign w_idle    = (r_state == ST_IDLE);
   assign w_accept  = w_idle & (memread | memwrite);
   assign w_adr_bad = (adr[1:0] != 2'b00) | (|adr[WIDTH-1:ADDRBITS+2]);

   // With LATENCY=1 RESP is entered straight from IDLE, so the live bus
   // inputs stand in for the capture registers on that edge.
   assign w_ra      = w_idle ? adr[ADDRBITS+1:2] : r_idx;
   assign w_cur_rd  = w_idle ? (memread & ~memwrite) : r_is_rd;
   assign w_cur_bad = w_idle ? w_adr_bad : r_bad;
   assign w_cur_err = w_idle ? (w_adr_bad | (memread & memwrite)) : r_err_req;

   assign w_enter_resp = (w_next_state == ST_RESP) && (r_state != ST_RESP);
   assign w_we         = (r_state == ST_RESP) & r_is_wr & ~r_bad;

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      unique case (r_state)
         ST_IDLE: begin
            if (memread | memwrite) begin
               if (LATENCY == 1) begin
                  w_next_state = ST_RESP;
               end else begin
                  w_next_state = ST_WAIT;
                  w_next_cnt   = CNT_W'(LATENCY - 1);
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_next_state = ST_RESP;
            end else begin
               w_next_cnt = r_cnt - 1'b1;
            end
         end
         ST_RESP: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // Both-set requests are treated as writes; the read half is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_is_wr   <= 1'b0;
         r_is_rd   <= 1'b0;
         r_bad     <= 1'b0;
         r_err_req <= 1'b0;
         r_idx     <= '0;
         r_wd      <= '0;
      end else if (w_accept) begin
         r_is_wr   <= memwrite;
         r_is_rd   <= memread & ~memwrite;
         r_bad     <= w_adr_bad;
         r_err_req <= w_adr_bad | (memread & memwrite);
         r_idx     <= adr[ADDRBITS+1:2];
         r_wd      <= writedata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_memdata <= '0;
      end else if (w_enter_resp && w_cur_rd) begin
         r_memdata <= w_cur_bad ? '0 : w_rd_data;
      end
   end

   // A new error outranks a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_enter_resp && w_cur_err) begin
         r_err <= 1'b1;
      end else if (err_clr) begin
         r_err <= 1'b0;
      end
   end

   mips_mem_array #(
      .WIDTH    (WIDTH),
      .ADDRBITS (ADDRBITS)
   ) u_array (
      .clk (clk),
      .we  (w_we),
      .wa  (r_idx),
      .wd  (r_wd),
      .ra  (w_ra),
      .rd  (w_rd_data)
   );

   assign memdata   = r_memdata;
   assign memready  = (r_state == ST_RESP);
   assign busy      = (r_state != ST_IDLE);
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: a LATENCY=2 instance driven transaction by
// transaction and a LATENCY=1 instance driven with held, streaming requests.
module tb_mips_mem_responder;

   localparam int W    = 32;
   localparam int LAT0 = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // LATENCY=2 instance
   logic         memread, memwrite, err_clr;
   logic [W-1:0] adr, writedata, memdata;
   logic         memready, busy, err;
   logic [1:0]   dbg_state;

   // LATENCY=1 instance
   logic         m1_read, m1_write, m1_clr;
   logic [W-1:0] m1_adr, m1_wd, m1_data;
   logic         m1_ready, m1_busy, m1_err;
   logic [1:0]   m1_dbg;

   mips_mem_responder #(.WIDTH(32), .ADDRBITS(8), .LATENCY(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .memread   (memread),
      .memwrite  (memwrite),
      .adr       (adr),
      .writedata (writedata),
      .memdata   (memdata),
      .memready  (memready),
      .busy      (busy),
      .err       (err),
      .err_clr   (err_clr),
      .dbg_state (dbg_state)
   );

   mips_mem_responder #(.WIDTH(32), .ADDRBITS(8), .LATENCY(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .memread   (m1_read),
      .memwrite  (m1_write),
      .adr       (m1_adr),
      .writedata (m1_wd),
      .memdata   (m1_data),
      .memready  (m1_ready),
      .busy      (m1_busy),
      .err       (m1_err),
      .err_clr   (m1_clr),
      .dbg_state (m1_dbg)
   );

   // ---------------- scoreboard state ----------------
   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp1_q[$];
   logic [W-1:0] model_mem [256];
   logic [W-1:0] vals1 [3];
   logic [W-1:0] last_rd;
   logic         err_m;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_req(input logic rd, input logic wr, input logic [W-1:0] a,
                         input logic [W-1:0] wd, input logic clr);
      logic         bad;
      logic         dual;
      logic [7:0]   idx;
      logic [W-1:0] exp_d;
      int           lat;
      int           busy_n;
      bad  = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
      dual = rd & wr;
      idx  = a[9:2];
      if (wr) begin
         if (!bad) model_mem[idx] = wd;
         exp_d = last_rd;
      end else begin
         exp_d   = bad ? '0 : model_mem[idx];
         last_rd = exp_d;
      end
      exp_q.push_back(exp_d);
      err_m = clr ? (bad | dual) : (err_m | bad | dual);

      @(negedge clk);
      memread = rd; memwrite = wr; adr = a; writedata = wd; err_clr = clr;
      @(posedge clk); #1;
      memread = 1'b0; memwrite = 1'b0; adr = $urandom; writedata = $urandom;
      lat    = 1;
      busy_n = 0;
      while (!memready && lat < 40) begin
         busy_n += int'(busy);
         @(posedge clk); #1;
         lat++;
      end
      busy_n += int'(busy);
      if (!memready) begin
         check("req_timeout", 32'(lat), 32'(LAT0));
         void'(exp_q.pop_front());
      end else begin
         check("latency", 32'(lat), 32'(LAT0));
         check("busy_cycles", 32'(busy_n), 32'(LAT0));
         check("memdata", memdata, exp_q.pop_front());
         check("err", 32'(err), 32'(err_m));
      end
      @(negedge clk);
      err_clr = 1'b0;
      @(posedge clk); #1;
      check("ready_pulse", 32'(memready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("memdata_hold", memdata, exp_d);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      err_m   = 1'b0;
      check("err_clr", 32'(err), 32'd0);
   endtask

   task automatic stream1(input logic wr);
      int cyc;
      @(negedge clk);
      m1_read = ~wr; m1_write = wr; m1_adr = '0; m1_wd = vals1[0];
      for (int k = 0; k < 3; k++) begin
         if (!wr) exp1_q.push_back(vals1[k]);
         cyc = 0;
         do begin
            @(posedge clk); #1;
            cyc++;
         end while (!m1_ready && cyc < 10);
         check("stream_gap", 32'(cyc), (k == 0) ? 32'd1 : 32'd2);
         if (!wr) check("stream_data", m1_data, exp1_q.pop_front());
         if (k < 2) begin
            m1_adr = 32'((k + 1) * 4);
            m1_wd  = vals1[k + 1];
         end else begin
            m1_read  = 1'b0;
            m1_write = 1'b0;
         end
      end
      @(posedge clk); #1;
      check("stream_idle", 32'(m1_busy), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int           kind;
      int           ridx;
      logic         seen;
      logic [W-1:0] a;
      reset = 1'b1;
      memread = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0; err_clr = 1'b0;
      m1_read = 1'b0; m1_write = 1'b0; m1_adr = '0; m1_wd = '0; m1_clr = 1'b0;
      last_rd = '0;
      err_m   = 1'b0;
      for (int i = 0; i < 256; i++) model_mem[i] = '0;
      for (int i = 0; i < 3; i++) vals1[i] = $urandom;

      repeat (3) @(posedge clk);
      #1;
      check("rst_memdata", memdata, 32'd0);
      check("rst_memready", 32'(memready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // write then read back
      do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

      // misaligned read, then clear
      do_req(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
      clr_pulse();

      // error raised while err_clr held: set wins
      do_req(1'b1, 1'b0, 32'h12, 32'h0, 1'b1);
      clr_pulse();

      // read+write together: write lands, err set
      do_req(1'b1, 1'b1, 32'h20, 32'h5, 1'b0);
      clr_pulse();
      do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

      // out-of-range write must not alias onto word 0
      do_req(1'b0, 1'b1, 32'h0, 32'hA5A55A5A, 1'b0);
      do_req(1'b0, 1'b1, 32'h400, 32'hFFFF, 1'b0);
      clr_pulse();
      do_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

      // random traffic over a preloaded window
      for (int i = 0; i < 16; i++) do_req(1'b0, 1'b1, 32'(i) << 2, $urandom, 1'b0);
      for (int i = 0; i < 24; i++) begin
         kind = $urandom_range(0, 9);
         ridx = $urandom_range(0, 15);
         a    = 32'(ridx) << 2;
         if (kind <= 3)      do_req(1'b1, 1'b0, a, 32'h0, $urandom_range(0, 3) == 0);
         else if (kind <= 6) do_req(1'b0, 1'b1, a, $urandom, $urandom_range(0, 3) == 0);
         else if (kind == 7) do_req(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), 32'h0, 1'b0);
         else if (kind == 8) do_req(1'b0, 1'b1, a | (32'($urandom_range(1, 1000)) << 10), $urandom, 1'b0);
         else                do_req(1'b1, 1'b1, a, $urandom, 1'b0);
      end

      // reset during WAIT aborts a pending write
      do_req(1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
      @(negedge clk);
      memwrite = 1'b1; adr = 32'h8; writedata = 32'h1234;
      @(posedge clk); #1;
      memwrite = 1'b0;
      check("abort_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("abort_busy_rst", 32'(busy), 32'd0);
      check("abort_memready", 32'(memready), 32'd0);
      check("abort_memdata", memdata, 32'd0);
      check("abort_err", 32'(err), 32'd0);
      check("abort_state", 32'(dbg_state), 32'd0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         seen |= memready;
      end
      check("abort_no_ready", 32'(seen), 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      last_rd = '0;
      err_m   = 1'b0;
      do_req(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

      // LATENCY=1 held-request streaming
      stream1(1'b1);
      stream1(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
